// File: rtl/ex_mdu.sv
// EX-stage iterative multiply/divide unit owning HI/LO; one bit per cycle, stalls the pipe while busy.
// Defining EX_MDU_MADD_EN enables the accumulating ops MADD/MADDU/MSUB/MSUBU (op 1xx).
module ex_mdu #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              cancel_i,
  input  logic              hi_we_i,
  input  logic              lo_we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_req_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              div_zero_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int PW    = 2 * DATA_W;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [PW-1:0]     p_q;
  logic [DATA_W-1:0] mcand_q, hi_q, lo_q;
  logic              div_q, a_neg_q, b_neg_q, div_zero_q;
`ifdef EX_MDU_MADD_EN
  logic              acc_q, sub_q;
`endif

  logic              legal_s, accept_s, is_div_s, a_neg_s, b_neg_s, b_zero_s, last_s;
  logic [DATA_W-1:0] a_mag_s, b_mag_s;
  logic [DATA_W:0]   add_s, shl_s, dif_s;
  logic [PW-1:0]     p_step_s, prod_s, res_s;
  logic [DATA_W-1:0] quot_s, rem_s;

`ifdef EX_MDU_MADD_EN
  assign legal_s = 1'b1;
`else
  assign legal_s = ~op_i[2];
`endif
  assign is_div_s = (op_i[2:1] == 2'b01);
  assign a_neg_s  = ~op_i[0] & a_i[DATA_W-1];
  assign b_neg_s  = ~op_i[0] & b_i[DATA_W-1];
  assign a_mag_s  = a_neg_s ? -a_i : a_i;
  assign b_mag_s  = b_neg_s ? -b_i : b_i;
  assign b_zero_s = (b_i == {DATA_W{1'b0}});
  assign accept_s = (state_q == S_IDLE) & start_i & legal_s & ~cancel_i;
  assign last_s   = (cnt_q == CNT_W'(DATA_W - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; divide by zero skips the iteration phase
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = (is_div_s && b_zero_s) ? S_DONE : S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (cancel_i) begin
          state_d = S_IDLE;
        end else if (last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CALC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs
  always_comb begin
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_DONE);
    div_zero_o  = (state_q == S_DONE) & div_zero_q;
    stall_req_o = accept_s | (state_q != S_IDLE);
  end

  // One iteration step: p_q holds {acc, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    add_s = {1'b0, p_q[PW-1:DATA_W]} + (p_q[0] ? {1'b0, mcand_q} : {(DATA_W+1){1'b0}});
    shl_s = {p_q[PW-1:DATA_W], p_q[DATA_W-1]};
    dif_s = shl_s - {1'b0, mcand_q};
    if (!div_q) begin
      p_step_s = {add_s, p_q[DATA_W-1:1]};
    end else if (dif_s[DATA_W]) begin
      p_step_s = {shl_s[DATA_W-1:0], p_q[DATA_W-2:0], 1'b0};
    end else begin
      p_step_s = {dif_s[DATA_W-1:0], p_q[DATA_W-2:0], 1'b1};
    end
  end

  // Sign fix-up and accumulation applied at commit
  always_comb begin
    quot_s = (a_neg_q ^ b_neg_q) ? -p_q[DATA_W-1:0] : p_q[DATA_W-1:0];
    rem_s  = a_neg_q ? -p_q[PW-1:DATA_W] : p_q[PW-1:DATA_W];
    prod_s = (a_neg_q ^ b_neg_q) ? -p_q : p_q;
    if (div_q) begin
      res_s = {rem_s, quot_s};
    end else begin
      res_s = prod_s;
`ifdef EX_MDU_MADD_EN
      if (acc_q) begin
        res_s = sub_q ? ({hi_q, lo_q} - prod_s) : ({hi_q, lo_q} + prod_s);
      end else begin
        res_s = prod_s;
      end
`endif
    end
  end

  // Datapath registers and HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= {CNT_W{1'b0}};
      p_q        <= {PW{1'b0}};
      mcand_q    <= {DATA_W{1'b0}};
      hi_q       <= {DATA_W{1'b0}};
      lo_q       <= {DATA_W{1'b0}};
      div_q      <= 1'b0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
`ifdef EX_MDU_MADD_EN
      acc_q      <= 1'b0;
      sub_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            cnt_q      <= {CNT_W{1'b0}};
            div_q      <= is_div_s;
            a_neg_q    <= a_neg_s;
            b_neg_q    <= b_neg_s;
            div_zero_q <= is_div_s & b_zero_s;
            mcand_q    <= is_div_s ? b_mag_s : a_mag_s;
            p_q        <= {{DATA_W{1'b0}}, (is_div_s ? a_mag_s : b_mag_s)};
`ifdef EX_MDU_MADD_EN
            acc_q      <= op_i[2];
            sub_q      <= op_i[1];
`endif
          end else begin
            if (hi_we_i) hi_q <= wdata_i;
            if (lo_we_i) lo_q <= wdata_i;
          end
        end
        S_CALC: begin
          p_q   <= p_step_s;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        S_DONE: begin
          if (!cancel_i && !div_zero_q) begin
            {hi_q, lo_q} <= res_s;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: directed corner cases plus randomized ops against an arithmetic model.
module tb_ex_mdu;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [2:0]    op_i = 3'd0;
  logic [W-1:0]  a_i = '0;
  logic [W-1:0]  b_i = '0;
  logic          cancel_i = 1'b0;
  logic          hi_we_i = 1'b0;
  logic          lo_we_i = 1'b0;
  logic [W-1:0]  wdata_i = '0;
  logic          stall_req_o, busy_o, done_o, div_zero_o;
  logic [W-1:0]  hi_o, lo_o;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  ex_mdu #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .cancel_i(cancel_i), .hi_we_i(hi_we_i), .lo_we_i(lo_we_i), .wdata_i(wdata_i),
    .stall_req_o(stall_req_o), .busy_o(busy_o), .done_o(done_o), .div_zero_o(div_zero_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic op_legal(input logic [2:0] op);
`ifdef EX_MDU_MADD_EN
    return 1'b1;
`else
    return ~op[2];
`endif
  endfunction

  // Returns {div_zero, hi, lo} as the unit should commit them
  function automatic logic [64:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
    longint sa, sb;
    logic [63:0] prod, q, r;
    if (op[0]) begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    if (op[2:1] == 2'b01) begin
      if (b == 32'd0) return {1'b1, hi, lo};
      q = sa / sb;
      r = sa % sb;
      return {1'b0, r[31:0], q[31:0]};
    end
    prod = sa * sb;
    if (!op[2]) return {1'b0, prod};
    if (op[1]) return {1'b0, {hi, lo} - prod};
    return {1'b0, {hi, lo} + prod};
  endfunction

  task automatic dwrite(input logic hw, input logic lw, input logic [31:0] d);
    hi_we_i = hw; lo_we_i = lw; wdata_i = d;
    tick();
    hi_we_i = 1'b0; lo_we_i = 1'b0;
    if (hw) hi_m = d;
    if (lw) lo_m = d;
    check("dwrite", {hi_o, lo_o}, {hi_m, lo_m});
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [64:0] exp;
    logic legal;
    int n;
    int lat;
    legal = op_legal(op);
    exp = ref_op(op, a, b, hi_m, lo_m);
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    #1;
    check({tag, "_stall"}, stall_req_o, legal);
    tick();
    start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
    op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
    check({tag, "_busy"}, busy_o, legal);
    check({tag, "_hold"}, {hi_o, lo_o}, {hi_m, lo_m});
    if (legal) begin
      n = 0;
      while (done_o !== 1'b1 && n < 80) begin
        start_i = (n == 5); hi_we_i = (n == 5); lo_we_i = (n == 5); wdata_i = $urandom;
        tick();
        n++;
      end
      start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
      lat = (op[2:1] == 2'b01 && b == 32'd0) ? 0 : W;
      check({tag, "_lat"}, n, lat);
      check({tag, "_dz"}, div_zero_o, exp[64]);
      check({tag, "_pre"}, {hi_o, lo_o}, {hi_m, lo_m});
      tick();
      {hi_m, lo_m} = exp[63:0];
      check({tag, "_res"}, {hi_o, lo_o}, {hi_m, lo_m});
      check({tag, "_idle"}, {busy_o, done_o}, 2'b00);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic seen;
    logic [2:0] rop;

    // Reset overrides requests
    start_i = 1'b1; hi_we_i = 1'b1; wdata_i = 32'hA5A5_A5A5; op_i = 3'b000;
    tick(); tick();
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", {done_o, div_zero_o}, 2'b00);
    check("rst_hilo", {hi_o, lo_o}, 64'd0);
    start_i = 1'b0; hi_we_i = 1'b0; rst = 1'b0;
    tick();
    check("rst_exit", {busy_o, stall_req_o}, 2'b00);

    dwrite(1'b1, 1'b0, 32'h11);
    dwrite(1'b0, 1'b1, 32'h22);
    run_op(3'b010, 32'd5, 32'd0, "div0");
    check("div0_spec", {hi_o, lo_o}, 64'h0000_0011_0000_0022);

    run_op(3'b000, 32'hFFFF_FFFE, 32'd3, "mult");
    check("mult_spec", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(3'b001, 32'hFFFF_FFFE, 32'd3, "multu");
    check("multu_spec", {hi_o, lo_o}, 64'h0000_0002_FFFF_FFFA);
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, "div");
    check("div_spec", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'b011, 32'd100, 32'd7, "divu");
    check("divu_spec", {hi_o, lo_o}, 64'h0000_0002_0000_000E);
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, "minm1");
    check("minm1_spec", {hi_o, lo_o}, 64'h0000_0000_8000_0000);

    // Cancel beats start in IDLE
    op_i = 3'b000; a_i = 32'd3; b_i = 32'd4; start_i = 1'b1; cancel_i = 1'b1;
    #1;
    check("cxs_stall", stall_req_o, 1'b0);
    tick();
    start_i = 1'b0; cancel_i = 1'b0;
    check("cxs_busy", busy_o, 1'b0);

    // Start wins over a same-cycle direct write
    hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
    run_op(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, "swr");

    // Cancel on cycle 20 of a MULT
    op_i = 3'b000; a_i = 32'd7; b_i = 32'd9; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (19) tick();
    check("cxl_busy_pre", busy_o, 1'b1);
    cancel_i = 1'b1;
    tick();
    cancel_i = 1'b0;
    check("cxl_idle", {busy_o, stall_req_o}, 2'b00);
    check("cxl_hilo", {hi_o, lo_o}, {hi_m, lo_m});
    seen = 1'b0;
    repeat (40) begin tick(); if (done_o) seen = 1'b1; end
    check("cxl_nodone", seen, 1'b0);

    // Reset on cycle 10 of a DIV
    op_i = 3'b010; a_i = 32'd1000; b_i = 32'd3; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
    check("mrst_busy", {busy_o, done_o}, 2'b00);
    check("mrst_hilo", {hi_o, lo_o}, 64'd0);
    seen = 1'b0;
    repeat (40) begin tick(); if (done_o) seen = 1'b1; end
    check("mrst_nodone", seen, 1'b0);

    // Accumulate op: legal only with the macro
    dwrite(1'b1, 1'b0, 32'h0);
    dwrite(1'b0, 1'b1, 32'hFFFF_FFFF);
    run_op(3'b100, 32'd1, 32'd1, "madd");
`ifdef EX_MDU_MADD_EN
    check("madd_spec", {hi_o, lo_o}, 64'h0000_0001_0000_0000);
`else
    check("madd_spec", {hi_o, lo_o}, 64'h0000_0000_FFFF_FFFF);
`endif

    // Randomized back-to-back ops
    for (int i = 0; i < 24; i++) begin
`ifdef EX_MDU_MADD_EN
      rop = 3'($urandom_range(0, 7));
`else
      rop = 3'($urandom_range(0, 3));
`endif
      if ((i % 3) == 0) dwrite(1'b1, 1'b1, $urandom);
      run_op(rop, pick(), pick(), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
